// File: rtl/skid_pipe.sv
// Two-entry skid buffer with fully registered data, valid and ready outputs.
// Optional stall counter and stall_cnt_o port are compiled in with SKID_PIPE_STALL_CNT_EN.
module skid_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_vld_i,
    output logic             data_rdy_o,
    output logic [WIDTH-1:0] data_o,
    output logic             data_vld_o,
    input  logic             data_rdy_i
`ifdef SKID_PIPE_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic [WIDTH-1:0] out_d;
    logic             up_xfer;
    logic             dn_xfer;

    assign up_xfer = data_vld_i && data_rdy_o;
    assign dn_xfer = data_vld_o && data_rdy_i;

    // Next-state and register-load decode; FULL never samples data_i since ready is low there.
    always_comb begin
        state_d = state_q;
        out_d   = data_o;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (up_xfer) begin
                    out_d   = data_i;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (up_xfer && dn_xfer) begin
                    out_d = data_i;
                end else if (up_xfer) begin
                    skid_d  = data_i;
                    state_d = ST_FULL;
                end else if (dn_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (dn_xfer) begin
                    out_d   = skid_q;
                    state_d = ST_BUSY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Handshake flags are decoded from the next state so both leave a flop directly.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_EMPTY;
            data_o     <= '0;
            skid_q     <= '0;
            data_vld_o <= 1'b0;
            data_rdy_o <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_o     <= out_d;
            skid_q     <= skid_d;
            data_vld_o <= (state_d != ST_EMPTY);
            data_rdy_o <= (state_d != ST_FULL);
        end
    end

`ifdef SKID_PIPE_STALL_CNT_EN
    localparam int unsigned    CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating count of edges where downstream holds off a valid word.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= '0;
        end else if (data_vld_o && !data_rdy_i && (stall_cnt_o != CNT_MAX)) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_skid_pipe.sv
// Directed and scoreboarded bench for skid_pipe; define SKID_PIPE_STALL_CNT_EN to include the counter test.
module tb_skid_pipe;

    localparam int unsigned WIDTH = 32;

    logic             clk_i;
    logic             rst_n_i;
    logic [WIDTH-1:0] data_i;
    logic             data_vld_i;
    logic             data_rdy_o;
    logic [WIDTH-1:0] data_o;
    logic             data_vld_o;
    logic             data_rdy_i;
`ifdef SKID_PIPE_STALL_CNT_EN
    logic [15:0]      stall_cnt_o;
`endif

    int vec_cnt;
    int err_cnt;

    skid_pipe #(.WIDTH(WIDTH)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .data_i     (data_i),
        .data_vld_i (data_vld_i),
        .data_rdy_o (data_rdy_o),
        .data_o     (data_o),
        .data_vld_o (data_vld_o),
        .data_rdy_i (data_rdy_i)
`ifdef SKID_PIPE_STALL_CNT_EN
        ,
        .stall_cnt_o(stall_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one edge and let outputs settle before sampling.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_n_i    = 1'b0;
        data_vld_i = 1'b0;
        data_rdy_i = 1'b0;
        data_i     = 32'hDEAD_BEEF;
        tick();
        vec_cnt++;
        if (data_o !== 32'h0 || data_vld_o !== 1'b0 || data_rdy_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_state: data_o=%h vld=%b rdy=%b, want 0/0/0", data_o, data_vld_o, data_rdy_o);
        end
        rst_n_i = 1'b1;
        tick();
        vec_cnt++;
        if (data_rdy_o !== 1'b1 || data_vld_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_release: rdy=%b vld=%b, want 1/0", data_rdy_o, data_vld_o);
        end
    endtask

    task automatic test_stream();
        data_rdy_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            data_i     = 32'(i);
            data_vld_i = 1'b1;
            tick();
            vec_cnt++;
            if (data_o !== 32'(i) || data_vld_o !== 1'b1 || data_rdy_o !== 1'b1) begin
                err_cnt++;
                $display("FAIL stream_%0d: data_o=%h vld=%b rdy=%b, want %h/1/1", i, data_o, data_vld_o, data_rdy_o, 32'(i));
            end
        end
        data_vld_i = 1'b0;
        tick();
        vec_cnt++;
        if (data_vld_o !== 1'b0 || data_rdy_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL stream_end: vld=%b rdy=%b, want 0/1", data_vld_o, data_rdy_o);
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] exp_d [5];
        logic             exp_r [5];
        exp_d = '{32'hA, 32'hA, 32'hA, 32'hB, 32'hC};
        exp_r = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        data_rdy_i = 1'b0;
        data_vld_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_i = (i == 0) ? 32'hA : (i == 1) ? 32'hB : 32'hC;
            if (i == 3) data_rdy_i = 1'b1;
            tick();
            vec_cnt++;
            if (data_o !== exp_d[i] || data_vld_o !== 1'b1 || data_rdy_o !== exp_r[i]) begin
                err_cnt++;
                $display("FAIL bp_step%0d: data_o=%h vld=%b rdy=%b, want %h/1/%b", i, data_o, data_vld_o, data_rdy_o, exp_d[i], exp_r[i]);
            end
        end
        data_vld_i = 1'b0;
        tick();
        vec_cnt++;
        if (data_vld_o !== 1'b0 || data_rdy_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL bp_empty: vld=%b rdy=%b, want 0/1", data_vld_o, data_rdy_o);
        end
    endtask

    task automatic test_drain();
        data_rdy_i = 1'b0;
        data_vld_i = 1'b1;
        data_i     = 32'h11;
        tick();
        data_i = 32'h22;
        tick();
        vec_cnt++;
        if (data_rdy_o !== 1'b0 || data_o !== 32'h11) begin
            err_cnt++;
            $display("FAIL drain_full: rdy=%b data_o=%h, want 0/11", data_rdy_o, data_o);
        end
        data_vld_i = 1'b0;
        data_rdy_i = 1'b1;
        tick();
        vec_cnt++;
        if (data_o !== 32'h22 || data_vld_o !== 1'b1 || data_rdy_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL drain_busy: data_o=%h vld=%b rdy=%b, want 22/1/1", data_o, data_vld_o, data_rdy_o);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            vec_cnt++;
            if (data_vld_o !== 1'b0 || data_rdy_o !== 1'b1) begin
                err_cnt++;
                $display("FAIL drain_empty%0d: vld=%b rdy=%b, want 0/1", i, data_vld_o, data_rdy_o);
            end
        end
    endtask

    task automatic test_reset_mid();
        data_rdy_i = 1'b0;
        data_vld_i = 1'b1;
        data_i     = 32'h5;
        tick();
        data_i = 32'h6;
        tick();
        vec_cnt++;
        if (data_rdy_o !== 1'b0 || data_o !== 32'h5) begin
            err_cnt++;
            $display("FAIL rstmid_full: rdy=%b data_o=%h, want 0/5", data_rdy_o, data_o);
        end
        rst_n_i    = 1'b0;
        data_vld_i = 1'b0;
        data_rdy_i = 1'b1;
        tick();
        vec_cnt++;
        if (data_o !== 32'h0 || data_vld_o !== 1'b0 || data_rdy_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL rstmid_reset: data_o=%h vld=%b rdy=%b, want 0/0/0", data_o, data_vld_o, data_rdy_o);
        end
        rst_n_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vec_cnt++;
            if (data_o !== 32'h0 || data_vld_o !== 1'b0 || data_rdy_o !== 1'b1) begin
                err_cnt++;
                $display("FAIL rstmid_after%0d: data_o=%h vld=%b rdy=%b, want 0/0/1", i, data_o, data_vld_o, data_rdy_o);
            end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] sb[$];
        logic [WIDTH-1:0] prev_d;
        logic [WIDTH-1:0] exp_w;
        logic             up;
        logic             dn;
        logic             stalled;
        for (int c = 0; c < 10000; c++) begin
            data_vld_i = 1'($urandom_range(0, 1));
            data_rdy_i = 1'($urandom_range(0, 1));
            data_i     = $urandom;
            up      = data_vld_i && data_rdy_o;
            dn      = data_vld_o && data_rdy_i;
            stalled = data_vld_o && !data_rdy_i;
            prev_d  = data_o;
            if (dn) begin
                vec_cnt++;
                if (sb.size() == 0) begin
                    err_cnt++;
                    $display("FAIL rand_dup: cycle %0d data_o=%h delivered with nothing outstanding", c, data_o);
                end else begin
                    exp_w = sb.pop_front();
                    if (data_o !== exp_w) begin
                        err_cnt++;
                        $display("FAIL rand_order: cycle %0d data_o=%h, want %h", c, data_o, exp_w);
                    end
                end
            end
            if (up) sb.push_back(data_i);
            tick();
            vec_cnt++;
            if (data_vld_o !== (sb.size() != 0) || data_rdy_o !== (sb.size() < 2)) begin
                err_cnt++;
                $display("FAIL rand_flags: cycle %0d vld=%b rdy=%b with %0d words outstanding", c, data_vld_o, data_rdy_o, sb.size());
            end
            if (stalled) begin
                vec_cnt++;
                if (data_o !== prev_d || data_vld_o !== 1'b1) begin
                    err_cnt++;
                    $display("FAIL rand_stall: cycle %0d data_o=%h vld=%b, want %h/1", c, data_o, data_vld_o, prev_d);
                end
            end
        end
        data_vld_i = 1'b0;
        data_rdy_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (data_vld_o && sb.size() != 0) begin
                exp_w = sb.pop_front();
                vec_cnt++;
                if (data_o !== exp_w) begin
                    err_cnt++;
                    $display("FAIL rand_drain: data_o=%h, want %h", data_o, exp_w);
                end
            end
            tick();
        end
        vec_cnt++;
        if (sb.size() != 0 || data_vld_o !== 1'b0) begin
            err_cnt++;
            $display("FAIL rand_final: %0d words lost, vld=%b, want 0/0", sb.size(), data_vld_o);
        end
    endtask

`ifdef SKID_PIPE_STALL_CNT_EN
    task automatic test_stall_cnt();
        rst_n_i    = 1'b0;
        data_vld_i = 1'b0;
        data_rdy_i = 1'b0;
        tick();
        rst_n_i = 1'b1;
        tick();
        vec_cnt++;
        if (stall_cnt_o !== 16'h0) begin
            err_cnt++;
            $display("FAIL cnt_reset: stall_cnt_o=%h, want 0000", stall_cnt_o);
        end
        data_vld_i = 1'b1;
        data_i     = 32'h77;
        tick();
        data_vld_i = 1'b0;
        vec_cnt++;
        if (stall_cnt_o !== 16'h0 || data_vld_o !== 1'b1) begin
            err_cnt++;
            $display("FAIL cnt_start: stall_cnt_o=%h vld=%b, want 0000/1", stall_cnt_o, data_vld_o);
        end
        repeat (10) tick();
        vec_cnt++;
        if (stall_cnt_o !== 16'd10) begin
            err_cnt++;
            $display("FAIL cnt_10: stall_cnt_o=%h, want 000a", stall_cnt_o);
        end
        repeat (65525) tick();
        vec_cnt++;
        if (stall_cnt_o !== 16'hFFFF) begin
            err_cnt++;
            $display("FAIL cnt_sat: stall_cnt_o=%h, want ffff", stall_cnt_o);
        end
        repeat (4465) tick();
        vec_cnt++;
        if (stall_cnt_o !== 16'hFFFF || data_o !== 32'h77) begin
            err_cnt++;
            $display("FAIL cnt_nowrap: stall_cnt_o=%h data_o=%h, want ffff/77", stall_cnt_o, data_o);
        end
    endtask
`endif

    initial begin
        vec_cnt    = 0;
        err_cnt    = 0;
        rst_n_i    = 1'b0;
        data_vld_i = 1'b0;
        data_rdy_i = 1'b0;
        data_i     = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_drain();
        test_reset_mid();
        test_random();
`ifdef SKID_PIPE_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
